// File: rtl/spiking_encoder_ctrl_if.sv
// Handshake/control bundle between the encoder sequencer and its datapath.
// master: sequencer side (drives enables/status); slave: datapath side.
interface spiking_encoder_ctrl_if #(
    parameter int TILE_W = 4
);
    logic              i_start;
    logic              network_cal_done;
    logic              i_layer1_load_w_finish;
    logic              i_load_d_once_done;
    logic              i_data_load_done;
    logic              i_spike_valid;
    logic              i_eyeriss_weight_load_done;
    logic              o_weight_sel;
    logic              o_feature_en;
    logic              o_busy;
    logic [TILE_W-1:0] o_tile_idx;
    logic [15:0]       o_tile_spike_cnt;
    logic              o_tile_cnt_valid;
    logic              o_encoder_done;
    logic              o_err_overrun;

    modport master (
        input  i_start, network_cal_done, i_layer1_load_w_finish,
        input  i_load_d_once_done, i_data_load_done, i_spike_valid,
        input  i_eyeriss_weight_load_done,
        output o_weight_sel, o_feature_en, o_busy, o_tile_idx,
        output o_tile_spike_cnt, o_tile_cnt_valid, o_encoder_done,
        output o_err_overrun
    );

    modport slave (
        output i_start, network_cal_done, i_layer1_load_w_finish,
        output i_load_d_once_done, i_data_load_done, i_spike_valid,
        output i_eyeriss_weight_load_done,
        input  o_weight_sel, o_feature_en, o_busy, o_tile_idx,
        input  o_tile_spike_cnt, o_tile_cnt_valid, o_encoder_done,
        input  o_err_overrun
    );
endinterface

// File: rtl/spiking_encoder_ctrl.sv
// Sequencer for the spiking encoder: layer 1 weight wait, per-tile feed and
// LIF drain, weight stream handoff to Eyeriss. Ports: s_clk, s_rst, bus.
module spiking_encoder_ctrl #(
    parameter int NUM_TILES    = 16,
    parameter int DRAIN_CYCLES = 10,
    parameter int TILE_W       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    spiking_encoder_ctrl_if.master bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]     DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [TILE_W-1:0] LAST_TILE  = TILE_W'(NUM_TILES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_HANDOFF = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [DW-1:0] drain_cnt;
    logic [15:0]   spike_cnt;
    logic [15:0]   spike_next;
    logic          counting;
    logic          drain_exit;
    logic          feed_entry;

    assign counting = (state == S_FEED) || (state == S_DRAIN);

    // Includes a spike sampled on the final drain cycle in the latched count.
    assign spike_next = (counting && bus.i_spike_valid && spike_cnt != 16'hFFFF)
                      ? spike_cnt + 16'd1 : spike_cnt;

    // An overrun pulse in DRAIN restarts the drain window instead of exiting.
    assign drain_exit = (state == S_DRAIN) && !bus.i_load_d_once_done
                      && (drain_cnt == '0);

    assign feed_entry = (next_state == S_FEED) && (state != S_FEED);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (bus.i_start) next_state = S_LOAD_W;
            S_LOAD_W:  if (bus.i_layer1_load_w_finish) next_state = S_FEED;
            S_FEED:    if (bus.i_load_d_once_done) next_state = S_DRAIN;
            S_DRAIN: begin
                if (drain_exit) begin
                    if (bus.o_tile_idx == LAST_TILE || bus.i_data_load_done)
                        next_state = S_HANDOFF;
                    else
                        next_state = S_FEED;
                end
            end
            S_HANDOFF: if (bus.i_eyeriss_weight_load_done) next_state = S_DONE;
            S_DONE:    if (bus.network_cal_done) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state                <= S_IDLE;
            drain_cnt            <= '0;
            spike_cnt            <= '0;
            bus.o_weight_sel     <= 1'b0;
            bus.o_feature_en     <= 1'b0;
            bus.o_busy           <= 1'b0;
            bus.o_tile_idx       <= '0;
            bus.o_tile_spike_cnt <= '0;
            bus.o_tile_cnt_valid <= 1'b0;
            bus.o_encoder_done   <= 1'b0;
            bus.o_err_overrun    <= 1'b0;
        end else begin
            state            <= next_state;
            bus.o_weight_sel <= (next_state == S_HANDOFF) || (next_state == S_DONE);
            bus.o_feature_en <= (next_state == S_FEED);
            bus.o_busy       <= (next_state != S_IDLE);
            bus.o_tile_cnt_valid <= drain_exit;
            bus.o_encoder_done   <= (state == S_HANDOFF) && (next_state == S_DONE);

            if (drain_exit)
                bus.o_tile_spike_cnt <= spike_next;

            if (state == S_IDLE || feed_entry)
                spike_cnt <= '0;
            else
                spike_cnt <= spike_next;

            if (state == S_IDLE)
                drain_cnt <= '0;
            else if (counting && bus.i_load_d_once_done)
                drain_cnt <= DRAIN_LOAD;
            else if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;

            if (state == S_IDLE)
                bus.o_tile_idx <= '0;
            else if (drain_exit && next_state == S_FEED)
                bus.o_tile_idx <= bus.o_tile_idx + 1'b1;

            // Later assignment wins: a stray tile pulse on the start cycle
            // still leaves the error flagged.
            if (state == S_IDLE && bus.i_start)
                bus.o_err_overrun <= 1'b0;
            if (state != S_FEED && bus.i_load_d_once_done)
                bus.o_err_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spiking_encoder_ctrl.sv
// Randomized and directed checks of spiking_encoder_ctrl against a
// phase-level reference model.
module tb_spiking_encoder_ctrl;
    localparam int NT = 4;
    localparam int DC = 10;
    localparam int TW = 2;

    typedef enum int {M_IDLE, M_LOADW, M_FEED, M_DRAIN, M_HAND, M_DONE} ph_t;

    logic s_clk = 1'b0;
    logic s_rst;
    always #5 s_clk = ~s_clk;

    spiking_encoder_ctrl_if #(.TILE_W(TW)) bus ();

    spiking_encoder_ctrl #(
        .NUM_TILES(NT), .DRAIN_CYCLES(DC), .TILE_W(TW)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .bus(bus)
    );

    int  n_vec = 0;
    int  n_bad = 0;
    ph_t ph;
    int  left, tile, spk, cnt_out;
    bit  m_valid, m_done, m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE; left = 0; tile = 0; spk = 0; cnt_out = 0;
        m_valid = 0; m_done = 0; m_err = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // One clock of the reference, using the inputs sampled at this edge.
    task automatic model_step();
        bit ld;
        ld = bus.i_load_d_once_done;
        m_valid = 0;
        m_done  = 0;
        case (ph)
            M_IDLE: begin
                tile = 0; spk = 0;
                if (bus.i_start) begin m_err = 0; ph = M_LOADW; end
                if (ld) m_err = 1;
            end
            M_LOADW: begin
                if (ld) m_err = 1;
                if (bus.i_layer1_load_w_finish) begin ph = M_FEED; spk = 0; end
            end
            M_FEED: begin
                if (bus.i_spike_valid) spk = sat_inc(spk);
                if (ld) begin ph = M_DRAIN; left = DC; end
            end
            M_DRAIN: begin
                if (bus.i_spike_valid) spk = sat_inc(spk);
                if (ld) begin
                    m_err = 1; left = DC;
                end else begin
                    left--;
                    if (left == 0) begin
                        cnt_out = spk; m_valid = 1;
                        if (tile == NT - 1 || bus.i_data_load_done) ph = M_HAND;
                        else begin tile++; ph = M_FEED; spk = 0; end
                    end
                end
            end
            M_HAND: begin
                if (ld) m_err = 1;
                if (bus.i_eyeriss_weight_load_done) begin ph = M_DONE; m_done = 1; end
            end
            M_DONE: begin
                if (ld) m_err = 1;
                if (bus.network_cal_done) ph = M_IDLE;
            end
            default: ph = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("weight_sel", bus.o_weight_sel, (ph == M_HAND || ph == M_DONE));
        chk("feature_en", bus.o_feature_en, (ph == M_FEED));
        chk("busy", bus.o_busy, (ph != M_IDLE));
        chk("tile_idx", bus.o_tile_idx, tile);
        chk("spike_cnt", bus.o_tile_spike_cnt, cnt_out);
        chk("cnt_valid", bus.o_tile_cnt_valid, m_valid);
        chk("enc_done", bus.o_encoder_done, m_done);
        chk("err_overrun", bus.o_err_overrun, m_err);
    endtask

    task automatic set_in(input bit st, wf, ld, dl, sp, ey, cd);
        bus.i_start = st;
        bus.i_layer1_load_w_finish = wf;
        bus.i_load_d_once_done = ld;
        bus.i_data_load_done = dl;
        bus.i_spike_valid = sp;
        bus.i_eyeriss_weight_load_done = ey;
        bus.network_cal_done = cd;
    endtask

    task automatic cycle();
        @(posedge s_clk);
        model_step();
        @(negedge s_clk);
        check_all();
    endtask

    task automatic drive_rand();
        set_in($urandom_range(99) < 20, $urandom_range(99) < 30,
               $urandom_range(99) < 8, $urandom_range(99) < 10,
               $urandom_range(99) < 50, $urandom_range(99) < 30,
               $urandom_range(99) < 30);
    endtask

    // Walk back to IDLE, pulsing the tile strobe only while feeding.
    task automatic to_idle();
        for (int i = 0; i < 80 && ph != M_IDLE; i++) begin
            set_in(0, 1, ph == M_FEED, 1, 0, 1, 1);
            cycle();
        end
        chk("reach_idle", bus.o_busy, 0);
    endtask

    task automatic to_feed();
        to_idle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("reach_feed", bus.o_feature_en, 1);
    endtask

    initial begin
        int n;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        s_rst = 1'b1;
        repeat (2) @(negedge s_clk);
        check_all();
        s_rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            drive_rand();
            cycle();
        end

        // Overrun: second tile strobe in the 4th drain cycle stretches DRAIN.
        to_feed();
        set_in(0, 0, 1, 0, 1, 0, 0);
        cycle();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            set_in(0, 0, n == 4, 0, 1, 0, 0);
            cycle();
            if (bus.o_tile_cnt_valid) break;
            n++;
        end
        chk("drain_len_ovr", n, 14);
        chk("ovr_sticky", bus.o_err_overrun, 1);

        // Saturation of the per-tile spike count.
        to_feed();
        for (int i = 0; i < 70000; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 0);
            cycle();
        end
        set_in(0, 0, 1, 0, 1, 0, 0);
        cycle();
        for (int i = 0; i < DC; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 0);
            cycle();
        end
        chk("sat_cnt", bus.o_tile_spike_cnt, 16'hFFFF);

        // Asynchronous reset in the middle of DRAIN, then restart.
        to_feed();
        set_in(0, 0, 1, 0, 1, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0);
        cycle();
        cycle();
        #2 s_rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge s_clk);
        check_all();
        s_rst = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("restart_busy", bus.o_busy, 1);
        chk("restart_tile", bus.o_tile_idx, 0);

        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
